// File: rtl/shift_right_unit.sv
// Multi-cycle right shifter: one bit per clock for SRL/SRA, with saturation for
// shift amounts above 31 and pass-through with an illegal flag for unknown codes.
module shift_right_unit #(
    parameter logic [5:0] SRL = 6'b000010,
    parameter logic [5:0] SRA = 6'b000011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in,
    input  logic [31:0] shamt,
    input  logic [5:0]  Signal,
    output logic [31:0] out,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] work;
    logic [4:0]  count;
    logic [5:0]  op;
    logic        sign;

    logic        legal_in;
    logic        big_in;
    logic [4:0]  n_in;

    assign legal_in = (Signal == SRL) || (Signal == SRA);
    assign big_in   = |shamt[31:5];
    // Saturated and illegal requests finish without any shift steps.
    assign n_in     = (!legal_in || big_in) ? 5'd0 : shamt[4:0];

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves state_next
        // unassigned, which would infer a latch.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (n_in == 5'd0) ? DONE : SHIFT;
            SHIFT:   if (count == 5'd1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work  <= '0;
            count <= '0;
            op    <= '0;
            sign  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op    <= Signal;
                        sign  <= in[31];
                        count <= n_in;
                        if (legal_in && big_in)
                            work <= (Signal == SRA) ? {32{in[31]}} : 32'd0;
                        else
                            work <= in;
                    end
                end
                SHIFT: begin
                    work  <= {(op == SRA) ? sign : 1'b0, work[31:1]};
                    count <= count - 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign out     = work;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign illegal = (state == DONE) && (op != SRL) && (op != SRA);

endmodule

// File: doc/shift_right_unit.md
SHIFT_RIGHT_UNIT -- requirements
Module: shift_right_unit

Interface
REQ-001 The block SHALL have one parameter: SRL, default 6'b000010, Signal code for logical right shift.
REQ-002 The block SHALL have one parameter: SRA, default 6'b000011, Signal code for arithmetic right shift.
REQ-003 The block SHALL have this port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 The block SHALL have this port: reset, input, 1, asynchronous, active-high.
REQ-005 The block SHALL have this port: start, input, 1, request to begin one shift.
REQ-006 The block SHALL have this port: in, input, 32, operand to shift.
REQ-007 The block SHALL have this port: shamt, input, 32, shift amount.
REQ-008 The block SHALL have this port: Signal, input, 6, function code selecting SRL or SRA.
REQ-009 The block SHALL have this port: out, output, 32, registered result.
REQ-010 The block SHALL have this port: busy, output, 1, operation in progress.
REQ-011 The block SHALL have this port: done, output, 1, one-cycle result-valid strobe.
REQ-012 The block SHALL have this port: illegal, output, 1, Signal was not SRL or SRA; valid only while done=1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 In IDLE, start=1 at a rising edge SHALL be accepted; this is edge E0.
REQ-015 At E0 the block SHALL latch in into the working register, Signal into an op register, and shamt into a count.
REQ-016 Effective count n SHALL be shamt[4:0] when shamt[31:5]==0.
REQ-017 When shamt[31:5]!=0, the result SHALL saturate at E0: 0 for SRL, all bits = in[31] for SRA; then n=0.
REQ-018 When Signal is neither SRL nor SRA, the result SHALL be in unchanged and n=0; illegal SHALL be 1 during the following done cycle.
REQ-019 At E0, when n=0 the next state SHALL be DONE; otherwise it SHALL be SHIFT.
REQ-020 Each edge in SHIFT SHALL shift the working register right by exactly 1 bit and decrement the count.
REQ-021 The shift fill bit SHALL be 0 for SRL and the latched in[31] for SRA.
REQ-022 When the count reaches 0, SHIFT SHALL go to DONE.
REQ-023 done SHALL be 1 in the cycle after edge E_n, so latency is n+1 cycles including the start cycle.
REQ-024 DONE SHALL return to IDLE unconditionally after one cycle, so done is high for exactly one cycle.
REQ-025 busy SHALL be 1 from the cycle after E0 through the done cycle inclusive, and 0 in IDLE.
REQ-026 start while busy=1, including during DONE, SHALL be ignored and SHALL NOT alter the operation in flight.
REQ-027 out SHALL equal the working register and SHALL hold the last result in IDLE until the next accepted start.
REQ-028 out SHALL be meaningful only when done=1; intermediate SHIFT values are not guaranteed.
REQ-029 Changes on in, shamt or Signal after E0 SHALL NOT affect the operation in flight.
REQ-030 The result SHALL equal in>>n (SRL) or $signed(in)>>>n (SRA), bit-exact over the 32-bit width, with shamt bits above bit 4 handled by saturation as in REQ-017.
REQ-031 SLL is not handled here; an SLL code (6'b000000) SHALL be treated as illegal.

Reset
REQ-032 reset=1 SHALL force, asynchronously and at any state including mid-SHIFT: state=IDLE, out=0, count=0, busy=0, done=0, illegal=0.
REQ-033 While reset=1, start SHALL be ignored.
REQ-034 The first start accepted after reset deasserts SHALL run normally.

Verification
REQ-035 SRL, in=32'hF000_0000, shamt=4, start one cycle -> busy for 5 cycles, done at the 5th, out=32'h0F00_0000, illegal=0.
REQ-036 SRA, in=32'h8000_0010, shamt=31 -> done 32 cycles after E0, out=32'hFFFF_FFFF; also shamt=0 -> done 1 cycle after E0, out=32'h8000_0010.
REQ-037 SRA, in=32'h8000_0000, shamt=32'h40 -> saturates, done 1 cycle after E0, out=32'hFFFF_FFFF; same with SRL -> out=0.
REQ-038 Signal=6'b000000, in=32'h1234_5678 -> done 1 cycle after E0, out=32'h1234_5678, illegal=1.
REQ-039 SRL shamt=10 in flight: pulse start with new operands mid-SHIFT -> ignored, original result delivered; then assert reset at cycle 3 of a new op -> out=0, busy=0, done=0 immediately without a clock edge.
REQ-040 Randomized stimulus: 1000 operations of SRL/SRA with random in and shamt (including values above 31) -> every result matches the REQ-030 model, and done pulses exactly once per accepted start.
